// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised MIPS register file for the decode stage. It has two
//   combinational read ports and one write port. It optionally forwards
//   a same-cycle write to the read ports. It keeps a busy bit per register
//   so the hazard unit can stall on results that are still pending.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           synchronous, active-high
//   RegWrite        write enable
//   WriteRegister   write index
//   WriteData       write data
//   ReserveValid    mark ReserveRegister as having a pending write
//   ReserveRegister index to reserve
//   ReadRegister1/2 read indices
//   ReadData1/2     read data (combinational)
//   Busy1/2         addressed register has an outstanding reserved write

module regfile_scoreboard #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                SP_INDEX = 29,
    parameter logic [DATA_W-1:0] SP_INIT  = 32'h7FFF_EFFC,
    parameter int                GP_INDEX = 28,
    parameter logic [DATA_W-1:0] GP_INIT  = 32'h1000_8000,
    parameter int                BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              ReserveValid,
    input  logic [ADDR_W-1:0] ReserveRegister,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Busy1,
    output logic              Busy2
);

    localparam int                Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SpIdx = ADDR_W'(SP_INDEX);
    localparam logic [ADDR_W-1:0] GpIdx = ADDR_W'(GP_INDEX);

    logic [DATA_W-1:0] regs [Depth];
    logic [Depth-1:0]  busy;
    logic [Depth-1:0]  busyNext;
    logic              bypass1;
    logic              bypass2;

    // Register array. On reset, everything is cleared except the stack and
    // global pointers. The later non-blocking assignments override the
    // blanket clear for those two entries. Writes to register 0 are
    // dropped so the entry never holds anything but zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs        <= '{default: '0};
            regs[SpIdx] <= SP_INIT;
            regs[GpIdx] <= GP_INIT;
        end else if (RegWrite && (WriteRegister != '0)) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    // Next scoreboard state. A completing write clears its busy bit first.
    // A new reservation is then applied, so a reservation to the same
    // register wins: the new long-latency op supersedes the one retiring.
    // Register 0 can never become busy.
    always_comb begin
        busyNext = busy;
        if (RegWrite) begin
            busyNext[WriteRegister] = 1'b0;
        end
        if (ReserveValid) begin
            busyNext[ReserveRegister] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    // Scoreboard register. Reset overrides any write or reservation
    // arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    // Detect a write that lands on the addressed register in this cycle.
    // When it does, the incoming data is forwarded and the register is no
    // longer reported busy, because its result is arriving now.
    always_comb begin
        bypass1 = (BYPASS != 0) && RegWrite && (WriteRegister == ReadRegister1)
                  && (ReadRegister1 != '0);
        bypass2 = (BYPASS != 0) && RegWrite && (WriteRegister == ReadRegister2)
                  && (ReadRegister2 != '0);
    end

    // Read port 1. Index 0 is hard-wired to zero and never busy.
    always_comb begin
        ReadData1 = '0;
        Busy1     = 1'b0;
        if (ReadRegister1 != '0) begin
            ReadData1 = bypass1 ? WriteData : regs[ReadRegister1];
            Busy1     = busy[ReadRegister1] && !bypass1;
        end
    end

    // Read port 2. This mirrors port 1, so both ports return the same
    // value when they address the same register.
    always_comb begin
        ReadData2 = '0;
        Busy2     = 1'b0;
        if (ReadRegister2 != '0) begin
            ReadData2 = bypass2 ? WriteData : regs[ReadRegister2];
            Busy2     = busy[ReadRegister2] && !bypass2;
        end
    end

endmodule
